tx_transmitter: RTL and testbench
=================================

# tx_transmitter

Serial frame transmitter that sits directly upstream of the network receiver and drives the 1-bit network line. It accepts a header (dest, src, length) and up to 16 payload bytes on a start strobe, then serializes one frame MSB-first: preamble, SFD, header, payload, and a CRC-8 over header and payload. Its bit format, field order and CRC are exactly those the receiver decodes.

## Interface
- `IFG_BITS`, default 8: idle (line-low) cycles inserted after each frame; legal range 1..255.
- `clk` input 1: single clock; one line bit per cycle.
- `rst_n` input 1: synchronous, active-low reset.
- `tx_start` input 1: frame request; honoured only when `tx_busy`=0.
- `dest_id` input 2: destination ID; header bits [7:6].
- `src_id` input 2: source ID; header bits [5:4].
- `length` input 4: payload byte count minus 1; header bits [3:0].
- `payload` input 128: right-aligned payload. The first byte sent is `payload[8*(length+1)-1 -: 8]`; the last byte sent is `payload[7:0]`. Bits above `8*(length+1)` are ignored.
- `tx_line` output 1: registered serial line; 0 when idle.
- `tx_busy` output 1: high from frame acceptance until the end of the IFG.
- `tx_done` output 1: one-cycle pulse in the first IFG cycle.

## Operation
- States:
  - IDLE: `tx_line`=0.
  - PREAMBLE: 16 bits of `16'b1010101010101010`.
  - SFD: 8 bits of `8'b10101011`.
  - HEADER: 8 bits of `{dest_id,src_id,length}`.
  - PAYLOAD: `8*(length+1)` bits.
  - CRC: 8 bits.
  - GAP: `IFG_BITS` cycles → IDLE.
- Every field is sent MSB-first.
- On acceptance, `dest_id`, `src_id`, `length` and `payload` are latched into a 128-bit shift register and header regs. Input changes during a frame have no effect.
- Counters:
  - 5-bit field counter for the preamble, SFD, header and CRC fields.
  - 8-bit payload bit counter, 0..`8*(length+1)-1`. Compute the bit length as `({4'b0,length}+1)<<3`, 8 bits wide, so that `length`=15 gives 128 without overflow.
- CRC-8:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - Updated on every bit transmitted in HEADER and PAYLOAD: `crc <= {crc[6:0],1'b0} ^ ((crc[7]^bit) ? 8'h07 : 8'h00)`.
  - Cleared to 0 in IDLE.
  - In CRC state, `crc[7]` is sent, then the register shifts left; it is not updated further.
- `tx_start` while `tx_busy`=1, including in GAP, is ignored and not queued.
- Reset (`rst_n`=0 at a rising edge), including mid-frame, forces on that edge: state IDLE, `tx_line`=0, `tx_busy`=0, `tx_done`=0, CRC=0, all counters 0.

## Timing
- Reset values: `tx_line`=0, `tx_busy`=0, `tx_done`=0.
- Let edge E0 be the edge that samples `tx_start`=1 in IDLE.
  - From E0: `tx_busy`=1, and `tx_line` carries preamble bit 0 (value 1) for the cycle after E0.
  - Each following edge advances one bit.
- Frame length is 48+8·(`length`+1)-8 = 48+8·`length` bits, so `length`=0 gives 48 bits and `length`=15 gives 168 bits.
- Bit offsets from E0:
  - Header: bits 24..31.
  - Payload: starts at bit 32.
  - CRC: the final 8 bits.
- After the last CRC bit's cycle, GAP lasts `IFG_BITS` cycles. During GAP, `tx_line`=0 and `tx_busy`=1, and `tx_done`=1 only in the first GAP cycle.
- `tx_busy` falls at the edge ending GAP. `tx_start` sampled on that same edge (state already IDLE) is not accepted. Acceptance happens at the next edge where IDLE and `tx_start`=1.
- Minimum frame-to-frame period is 48+8·`length`+`IFG_BITS`+1 cycles.

## Test plan
- Reset, then hold `tx_start`=0 for 20 cycles -> `tx_line`, `tx_busy`, `tx_done` all remain 0.
- `dest_id`=0, `src_id`=1, `length`=0, `payload`=0, pulse `tx_start` -> exactly 48 bits of AAAA, AB, 10, 00, 57 (hex, MSB-first). `tx_done` pulses once, 48 cycles after E0. `tx_busy` lasts 48+8 cycles.
- `length`=15 with `payload` = 128'h00112233445566778899AABBCCDDEEFF -> 168 bits. Payload is sent 00 first and FF last. CRC equals the golden-model CRC-8/0x07 over the 17 bytes. A loopback receiver reports `frame_valid`=1, `crc_error`=0, and matching dest/src/payload.
- Pulse `tx_start` again mid-frame and change `payload`/`length` mid-frame -> the output bitstream is identical to the undisturbed frame. No second frame is sent.
- Assert `rst_n`=0 during PAYLOAD -> next cycle `tx_line`=0 and `tx_busy`=0, with no `tx_done`. A new `tx_start` then yields a correct complete frame.
- Back-to-back: hold `tx_start`=1 continuously with `IFG_BITS`=8 and `length`=0 -> frames start every 57 cycles, each separated by 8 zero bits. Every frame is received valid by the loopback receiver.

Source files
------------

// File: rtl/tx_transmitter.sv
//==============================================================================
// tx_transmitter : serial frame transmitter, MSB-first
//   preamble / SFD / header / payload / CRC-8 (0x07), then an idle gap.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tx_transmitter #(
  parameter int IFG_BITS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tx_start,
  input  logic [1:0]   dest_id,
  input  logic [1:0]   src_id,
  input  logic [3:0]   length,
  input  logic [127:0] payload,
  output logic         tx_line,
  output logic         tx_busy,
  output logic         tx_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_HEADER, S_PAYLOAD, S_CRC, S_GAP
  } state_t;

  localparam logic [15:0] c_pre     = 16'hAAAA;
  localparam logic [7:0]  c_sfd     = 8'hAB;
  localparam logic [7:0]  c_ifg_end = 8'(IFG_BITS - 1);

  state_t         r_state, w_state_nxt;
  logic [4:0]     r_fcnt, w_fcnt_nxt;
  logic [7:0]     r_pcnt, w_pcnt_nxt;
  logic           r_line, w_line_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_done, w_done_nxt;
  logic [7:0]     r_crc;
  logic [7:0]     r_hdr;
  logic [127:0]   r_shift;
  logic [3:0]     r_len;
  logic           w_load, w_hdr_shift, w_pl_shift, w_crc_upd, w_crc_shift;
  logic [7:0]     w_bitlen;
  logic [6:0]     w_align;

  // Width kept at 8 so length=15 yields 128 without wrapping.
  assign w_bitlen = ({4'b0000, r_len} + 8'd1) << 3;
  // Left-align the payload so its first byte sits at bit 127.
  assign w_align  = {4'd15 - length, 3'b000};

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_pcnt_nxt  = r_pcnt;
    w_line_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_hdr_shift = 1'b0;
    w_pl_shift  = 1'b0;
    w_crc_upd   = 1'b0;
    w_crc_shift = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tx_start) begin
          w_state_nxt = S_PREAMBLE;
          w_fcnt_nxt  = 5'd0;
          w_line_nxt  = c_pre[15];
          w_busy_nxt  = 1'b1;
          w_load      = 1'b1;
        end
      end
      S_PREAMBLE: begin
        if (r_fcnt == 5'd15) begin
          w_state_nxt = S_SFD;
          w_fcnt_nxt  = 5'd0;
          w_line_nxt  = c_sfd[7];
        end else begin
          w_fcnt_nxt  = r_fcnt + 5'd1;
          w_line_nxt  = c_pre[4'd14 - r_fcnt[3:0]];
        end
      end
      S_SFD: begin
        if (r_fcnt == 5'd7) begin
          w_state_nxt = S_HEADER;
          w_fcnt_nxt  = 5'd0;
          w_line_nxt  = r_hdr[7];
          w_hdr_shift = 1'b1;
          w_crc_upd   = 1'b1;
        end else begin
          w_fcnt_nxt  = r_fcnt + 5'd1;
          w_line_nxt  = c_sfd[3'd6 - r_fcnt[2:0]];
        end
      end
      S_HEADER: begin
        w_line_nxt = (r_fcnt == 5'd7) ? r_shift[127] : r_hdr[7];
        w_crc_upd  = 1'b1;
        if (r_fcnt == 5'd7) begin
          w_state_nxt = S_PAYLOAD;
          w_pcnt_nxt  = 8'd0;
          w_pl_shift  = 1'b1;
        end else begin
          w_fcnt_nxt  = r_fcnt + 5'd1;
          w_hdr_shift = 1'b1;
        end
      end
      S_PAYLOAD: begin
        if (r_pcnt == w_bitlen - 8'd1) begin
          w_state_nxt = S_CRC;
          w_fcnt_nxt  = 5'd0;
          w_line_nxt  = r_crc[7];
          w_crc_shift = 1'b1;
        end else begin
          w_pcnt_nxt  = r_pcnt + 8'd1;
          w_line_nxt  = r_shift[127];
          w_pl_shift  = 1'b1;
          w_crc_upd   = 1'b1;
        end
      end
      S_CRC: begin
        if (r_fcnt == 5'd7) begin
          w_state_nxt = S_GAP;
          w_fcnt_nxt  = 5'd0;
          w_pcnt_nxt  = 8'd0;
          w_done_nxt  = 1'b1;
        end else begin
          w_fcnt_nxt  = r_fcnt + 5'd1;
          w_line_nxt  = r_crc[7];
          w_crc_shift = 1'b1;
        end
      end
      S_GAP: begin
        if (r_pcnt == c_ifg_end) begin
          w_state_nxt = S_IDLE;
          w_pcnt_nxt  = 8'd0;
          w_busy_nxt  = 1'b0;
        end else begin
          w_pcnt_nxt  = r_pcnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_fcnt  <= 5'd0;
      r_pcnt  <= 8'd0;
      r_line  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_crc   <= 8'd0;
      r_hdr   <= 8'd0;
      r_shift <= 128'd0;
      r_len   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_line  <= w_line_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_hdr   <= {dest_id, src_id, length};
        r_len   <= length;
        r_shift <= payload << w_align;
      end else begin
        if (w_hdr_shift) r_hdr   <= {r_hdr[6:0], 1'b0};
        if (w_pl_shift)  r_shift <= {r_shift[126:0], 1'b0};
      end
      // The bit going onto the line this edge is folded into the CRC now.
      if (r_state == S_IDLE)
        r_crc <= 8'd0;
      else if (w_crc_upd)
        r_crc <= {r_crc[6:0], 1'b0} ^ ((r_crc[7] ^ w_line_nxt) ? 8'h07 : 8'h00);
      else if (w_crc_shift)
        r_crc <= {r_crc[6:0], 1'b0};
    end
  end

  assign tx_line = r_line;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tx_transmitter.sv
// Directed bench for tx_transmitter: vector table plus multi-cycle sequences.
`default_nettype none

module tb_tx_transmitter;

  localparam int IFG = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tx_start;
  logic [1:0]   dest_id;
  logic [1:0]   src_id;
  logic [3:0]   length;
  logic [127:0] payload;
  logic         tx_line;
  logic         tx_busy;
  logic         tx_done;

  tx_transmitter #(.IFG_BITS(IFG)) dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start),
    .dest_id(dest_id), .src_id(src_id), .length(length), .payload(payload),
    .tx_line(tx_line), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   dest;
    logic [1:0]   src;
    logic [3:0]   len;
    logic [127:0] pl;
    logic [7:0]   exp_hdr;
    bit           crc_hand;
    logic [7:0]   exp_crc;
  } vec_t;

  vec_t          vecs[5];
  int            n_vec  = 0;
  int            n_fail = 0;
  int            cyc    = 0;
  int            last_e0;
  logic [167:0]  cap;

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic chk(input string name, input logic [167:0] act, input logic [167:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Golden frame, left-aligned in 168 bits, built bytewise.
  function automatic void build(input vec_t v, output logic [167:0] f, output int n);
    logic [7:0] b, crc;
    int L;
    L = int'(v.len);
    f = '0;
    n = 48 + 8 * L;
    f[167 -: 24] = 24'hAAAAAB;
    b = {v.dest, v.src, v.len};
    f[143 -: 8] = b;
    crc = crc_byte(8'h00, b);
    for (int j = 0; j <= L; j++) begin
      b = v.pl[8 * (L - j) + 7 -: 8];
      f[135 - 8 * j -: 8] = b;
      crc = crc_byte(crc, b);
    end
    f[135 - 8 * (L + 1) -: 8] = crc;
  endfunction

  task automatic run_frame(input vec_t v, input bit hold, input int disturb_at,
                           input int rst_at, input string tag);
    logic [167:0] exp, mask;
    logic [7:0]   res;
    int n, bad_ctl, k, gap_bad;
    build(v, exp, n);
    dest_id = v.dest; src_id = v.src; length = v.len; payload = v.pl;
    tx_start = 1'b1;
    tick();
    last_e0 = cyc;
    if (!hold) tx_start = 1'b0;
    cap = '0;
    bad_ctl = 0;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk({tag, "_rst_outputs"}, 168'({tx_line, tx_busy, tx_done}), 168'd0);
        return;
      end
      cap[167 - i] = tx_line;
      if (!tx_busy || tx_done) bad_ctl++;
      if (i == disturb_at) begin
        tx_start = 1'b1;
        payload  = ~v.pl;
        length   = ~v.len;
        dest_id  = ~v.dest;
        src_id   = ~v.src;
      end
      tick();
    end
    if (disturb_at >= 0) tx_start = 1'b0;
    mask = ~168'd0 << (168 - n);
    chk({tag, "_frame"}, cap & mask, exp);
    chk({tag, "_hdr"}, 168'(cap[143 -: 8]), 168'(v.exp_hdr));
    if (v.crc_hand) chk({tag, "_crc"}, 168'(cap[167 - n + 8 -: 8]), 168'(v.exp_crc));
    res = 8'h00;
    for (int j = 3; j < n / 8; j++) res = crc_byte(res, cap[167 - 8 * j -: 8]);
    chk({tag, "_crc_residue"}, 168'(res), 168'd0);
    chk({tag, "_done_start_gap"}, 168'({tx_done, tx_busy, tx_line}), 168'(3'b110));
    chk({tag, "_busy_done_in_frame"}, 168'(bad_ctl), 168'd0);
    k = 0; gap_bad = 0;
    while (tx_busy && k < 300) begin
      tick(); k++;
      if (tx_done || tx_line) gap_bad++;
    end
    chk({tag, "_gap_len"}, 168'(k), 168'(IFG));
    chk({tag, "_gap_quiet"}, 168'(gap_bad), 168'd0);
  endtask

  task automatic idle_check(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (tx_line || tx_busy || tx_done) bad++;
    end
    chk(name, 168'(bad), 168'd0);
  endtask

  initial begin
    int prev_e0;
    vecs[0] = '{2'd0, 2'd1, 4'd0,  128'd0, 8'h10, 1'b1, 8'h57};
    vecs[1] = '{2'd0, 2'd0, 4'd0,  128'd0, 8'h00, 1'b1, 8'h00};
    vecs[2] = '{2'd3, 2'd2, 4'd15, 128'h00112233445566778899AABBCCDDEEFF, 8'hEF, 1'b0, 8'h00};
    vecs[3] = '{2'd2, 2'd1, 4'd3,  128'hCAFE0000_00000000_00000000_DEADBEEF, 8'h93, 1'b0, 8'h00};
    vecs[4] = '{2'd1, 2'd3, 4'd7,  128'h0123456789ABCDEF_FEDCBA9876543210, 8'h77, 1'b0, 8'h00};

    rst_n = 1'b0; tx_start = 1'b0; dest_id = '0; src_id = '0; length = '0; payload = '0;
    repeat (3) tick();
    chk("reset_values", 168'({tx_line, tx_busy, tx_done}), 168'd0);
    rst_n = 1'b1;
    idle_check("idle_20", 20);

    for (int t = 0; t < 5; t++) run_frame(vecs[t], 1'b0, -1, -1, $sformatf("vec%0d", t));

    // Mid-frame restart request and input changes must not disturb the frame.
    run_frame(vecs[2], 1'b0, 60, -1, "disturb");
    idle_check("no_second_frame", 20);

    // Reset during payload, then a clean frame.
    run_frame(vecs[3], 1'b0, -1, 40, "midrst");
    tx_start = 1'b0;
    idle_check("after_rst_idle", 5);
    run_frame(vecs[3], 1'b0, -1, -1, "post_rst");

    // Back-to-back with tx_start held high.
    run_frame(vecs[0], 1'b1, -1, -1, "b2b0");
    for (int f = 1; f < 3; f++) begin
      prev_e0 = last_e0;
      run_frame(vecs[0], 1'b1, -1, -1, $sformatf("b2b%0d", f));
      chk($sformatf("b2b%0d_period", f), 168'(last_e0 - prev_e0), 168'd57);
    end
    tx_start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
